// File: rtl/way_line_select_pkg.sv
// way_select_pkg
// Shared types and width helpers for the registered way/line selector.
//   - idx_w()      : index width for a count of n items (minimum 1 bit)
//   - buf_state_t  : occupancy of the two-entry output buffer
//   - entry_t      : one buffered result {line, word, err} at default widths
package way_select_pkg;

  localparam int LINE_SIZE_DEF = 512;
  localparam int WAYS_DEF      = 8;
  localparam int WORD_SIZE_DEF = 32;
  localparam int ERR_CNT_W_DEF = 16;

  // A single-item select still needs a 1-bit index port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int WAY_IDX_W  = idx_w(WAYS_DEF);
  localparam int WORD_IDX_W = idx_w(LINE_SIZE_DEF / WORD_SIZE_DEF);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  typedef struct packed {
    logic [LINE_SIZE_DEF-1:0] line;
    logic [WORD_SIZE_DEF-1:0] word;
    logic                     err;
  } entry_t;

endpackage

// File: rtl/way_line_select_if.sv
// way_line_select_if
// Request/response bundle between the hit logic (master) and the way
// selector (slave).
//   request : in_valid, in_ready, way_sel, word_sel, word_mode, lines
//   response: out_valid, out_ready, out_line, out_word, out_err
//   status  : err_count
interface way_line_select_if
  import way_select_pkg::*;
#(
  parameter int LINE_SIZE = 512,
  parameter int WAYS      = 8,
  parameter int WORD_SIZE = 32,
  parameter int ERR_CNT_W = 16
) ();

  localparam int WAY_W  = idx_w(WAYS);
  localparam int WORD_W = idx_w(LINE_SIZE / WORD_SIZE);

  logic                      in_valid;
  logic                      in_ready;
  logic [WAY_W-1:0]          way_sel;
  logic [WORD_W-1:0]         word_sel;
  logic                      word_mode;
  logic [WAYS*LINE_SIZE-1:0] lines;

  logic                      out_valid;
  logic                      out_ready;
  logic [LINE_SIZE-1:0]      out_line;
  logic [WORD_SIZE-1:0]      out_word;
  logic                      out_err;
  logic [ERR_CNT_W-1:0]      err_count;

  modport master (
    output in_valid, way_sel, word_sel, word_mode, lines, out_ready,
    input  in_ready, out_valid, out_line, out_word, out_err, err_count
  );

  modport slave (
    input  in_valid, way_sel, word_sel, word_mode, lines, out_ready,
    output in_ready, out_valid, out_line, out_word, out_err, err_count
  );

endinterface

// File: rtl/way_line_select_skid.sv
// way_select_skid
// Generic two-entry valid/ready buffer (head + skid register).
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : upstream handshake, in_data payload
//   out_valid/out_ready: downstream handshake, out_data = head entry
// in_ready and out_valid are registers, so neither handshake side has a
// combinational path to the other.
module way_select_skid
  import way_select_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_t   state_reg;
  logic [W-1:0] head_reg;
  logic [W-1:0] skid_reg;
  logic         in_ready_reg;
  logic         out_valid_reg;

  logic push;
  logic pop;

  assign push = in_valid && in_ready_reg;
  assign pop  = out_valid_reg && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= EMPTY;
      head_reg      <= '0;
      skid_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (push) begin
            head_reg      <= in_data;
            state_reg     <= ONE;
            out_valid_reg <= 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            skid_reg     <= in_data;
            state_reg    <= TWO;
            in_ready_reg <= 1'b0;
          end else if (!push && pop) begin
            state_reg     <= EMPTY;
            out_valid_reg <= 1'b0;
          end else if (push && pop) begin
            // Old head leaves this edge; new entry takes its place.
            head_reg <= in_data;
          end
        end
        TWO: begin
          if (pop) begin
            head_reg     <= skid_reg;
            state_reg    <= ONE;
            in_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= EMPTY;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = head_reg;

endmodule

// File: rtl/way_line_select.sv
// way_line_select
// Registered way multiplexor: picks one line out of WAYS concatenated lines,
// optionally extracts one word, flags out-of-range way indices, and returns
// the result through a two-entry buffer one cycle after accept.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of way_line_select_if (request, response, err_count)
module way_line_select
  import way_select_pkg::*;
#(
  parameter int LINE_SIZE = 512,
  parameter int WAYS      = 8,
  parameter int WORD_SIZE = 32,
  parameter int ERR_CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  way_line_select_if.slave bus
);

  localparam int WORDS  = LINE_SIZE / WORD_SIZE;
  localparam int WAY_W  = idx_w(WAYS);
  localparam int WORD_W = idx_w(WORDS);

  typedef struct packed {
    logic [LINE_SIZE-1:0] line;
    logic [WORD_SIZE-1:0] word;
    logic                 err;
  } payload_t;

  logic [LINE_SIZE-1:0] way_line [WAYS];
  logic [LINE_SIZE-1:0] sel_line;
  logic [WORD_SIZE-1:0] sel_word;
  logic                 sel_err;
  payload_t             in_entry;
  payload_t             out_entry;
  logic                 in_ready;
  logic                 accept;
  logic [ERR_CNT_W-1:0] err_count_reg;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign way_line[gi] = bus.lines[gi*LINE_SIZE +: LINE_SIZE];
  end

  // Compare against every legal way rather than indexing directly, so an
  // out-of-range way_sel (non-power-of-two WAYS) falls through to zero.
  always_comb begin
    sel_line = '0;
    sel_err  = (32'(bus.way_sel) >= WAYS);
    for (int w = 0; w < WAYS; w++) begin
      if (bus.way_sel == WAY_W'(w)) begin
        sel_line = way_line[w];
      end
    end
  end

  always_comb begin
    sel_word = '0;
    if (bus.word_mode) begin
      for (int n = 0; n < WORDS; n++) begin
        if (bus.word_sel == WORD_W'(n)) begin
          sel_word = sel_line[n*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
  end

  assign in_entry = '{line: sel_line, word: sel_word, err: sel_err};
  assign accept   = bus.in_valid && in_ready;

  way_select_skid #(
    .W($bits(payload_t))
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.in_valid),
    .in_ready (in_ready),
    .in_data  (in_entry),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data (out_entry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_reg <= '0;
    end else if (accept && sel_err && (err_count_reg != '1)) begin
      err_count_reg <= err_count_reg + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_line  = out_entry.line;
  assign bus.out_word  = out_entry.word;
  assign bus.out_err   = out_entry.err;
  assign bus.err_count = err_count_reg;

endmodule

// File: tb/tb_way_line_select.sv
module tb_way_line_select;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  way_line_select_if #(.LINE_SIZE(512), .WAYS(8), .WORD_SIZE(32), .ERR_CNT_W(16)) bus8 ();
  way_line_select_if #(.LINE_SIZE(512), .WAYS(6), .WORD_SIZE(32), .ERR_CNT_W(2))  bus6 ();

  way_line_select #(.LINE_SIZE(512), .WAYS(8), .WORD_SIZE(32), .ERR_CNT_W(16)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );
  way_line_select #(.LINE_SIZE(512), .WAYS(6), .WORD_SIZE(32), .ERR_CNT_W(2)) dut6 (
    .clk(clk), .rst(rst), .bus(bus6)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] pat(input int w);
    return {16{32'(w)}};
  endfunction

  typedef struct {
    logic [511:0] line;
    logic [31:0]  word;
    int           way;
  } exp_t;

  exp_t q[$];

  initial begin
    int sent;
    int cyc;
    int way_r;
    int wsel_r;
    logic mode_r;
    exp_t e;
    logic [511:0] held;
    logic hold_chk;

    rst = 1'b1;
    bus8.in_valid = 0; bus8.way_sel = 0; bus8.word_sel = 0; bus8.word_mode = 0; bus8.out_ready = 0;
    bus6.in_valid = 0; bus6.way_sel = 0; bus6.word_sel = 0; bus6.word_mode = 0; bus6.out_ready = 0;
    for (int w = 0; w < 8; w++) bus8.lines[w*512 +: 512] = pat(w);
    for (int w = 0; w < 6; w++) bus6.lines[w*512 +: 512] = pat(w);
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus8.in_ready, 1);
    check("rst_out_valid", bus8.out_valid, 0);
    check("rst_out_line", bus8.out_line, 0);
    check("rst_out_word", bus8.out_word, 0);
    check("rst_out_err", bus8.out_err, 0);
    check("rst_err_count", bus8.err_count, 0);
    rst = 1'b0;
    tick();

    // Line select, no word extraction
    $display("txn: way 5 line only");
    bus8.out_ready = 1; bus8.in_valid = 1; bus8.way_sel = 5; bus8.word_mode = 0;
    tick();
    bus8.in_valid = 0;
    check("t1_valid", bus8.out_valid, 1);
    check("t1_line", bus8.out_line, pat(5));
    check("t1_word", bus8.out_word, 0);
    check("t1_err", bus8.out_err, 0);
    tick();
    check("t1_drained", bus8.out_valid, 0);

    // Word extraction from the last word
    $display("txn: way 3 word 15");
    bus8.in_valid = 1; bus8.way_sel = 3; bus8.word_sel = 15; bus8.word_mode = 1;
    tick();
    bus8.in_valid = 0;
    check("t2_line", bus8.out_line, pat(3));
    check("t2_word", bus8.out_word, 32'h3);
    tick();

    // Back-pressure: ways 1, 2, 3 with out_ready low
    $display("txn: back-pressure ways 1,2,3");
    bus8.out_ready = 0; bus8.word_mode = 0;
    bus8.in_valid = 1; bus8.way_sel = 1;
    tick();
    check("bp_ready_one", bus8.in_ready, 1);
    bus8.way_sel = 2;
    tick();
    check("bp_ready_two", bus8.in_ready, 0);
    check("bp_head1", bus8.out_line, pat(1));
    bus8.way_sel = 3;
    tick();
    check("bp_held_ready", bus8.in_ready, 0);
    check("bp_held_head", bus8.out_line, pat(1));
    bus8.out_ready = 1;
    tick();
    check("bp_head2", bus8.out_line, pat(2));
    check("bp_ready_again", bus8.in_ready, 1);
    tick();
    bus8.in_valid = 0;
    check("bp_head3", bus8.out_line, pat(3));
    check("bp_valid3", bus8.out_valid, 1);
    tick();
    check("bp_empty", bus8.out_valid, 0);

    // Out-of-range way on the 6-way instance, saturating counter
    $display("txn: ways=6 way_sel 5 then 7 x5");
    bus6.out_ready = 1; bus6.in_valid = 1; bus6.way_sel = 5;
    tick();
    check("w6_line5", bus6.out_line, pat(5));
    check("w6_err5", bus6.out_err, 0);
    bus6.way_sel = 7;
    tick();
    check("w6_err", bus6.out_err, 1);
    check("w6_line0", bus6.out_line, 0);
    check("w6_cnt1", bus6.err_count, 1);
    tick();
    check("w6_cnt2", bus6.err_count, 2);
    repeat (3) tick();
    bus6.in_valid = 0;
    check("w6_cnt_sat", bus6.err_count, 3);
    tick();

    // Random streaming with scoreboard
    sent = 0; cyc = 0; hold_chk = 0; held = '0;
    while ((sent < 100 || q.size() > 0) && cyc < 3000) begin
      if (sent < 100) begin
        for (int i = 0; i < 128; i++) bus8.lines[i*32 +: 32] = $urandom;
        way_r  = $urandom_range(0, 7);
        wsel_r = $urandom_range(0, 15);
        mode_r = 1'($urandom_range(0, 1));
        bus8.in_valid  = ($urandom_range(0, 9) < 7);
        bus8.way_sel   = 3'(way_r);
        bus8.word_sel  = 4'(wsel_r);
        bus8.word_mode = mode_r;
        bus8.out_ready = ($urandom_range(0, 9) < 6);
      end else begin
        bus8.in_valid  = 0;
        bus8.out_ready = 1;
      end
      if (hold_chk) check("stream_hold", bus8.out_line, held);
      hold_chk = bus8.out_valid && !bus8.out_ready;
      held = bus8.out_line;
      if (bus8.out_valid && bus8.out_ready) begin
        if (q.size() == 0) begin
          check("stream_spurious", 1, 0);
        end else begin
          e = q.pop_front();
          check("stream_line", bus8.out_line, e.line);
          check("stream_word", bus8.out_word, e.word);
          check("stream_err", bus8.out_err, 0);
          $display("txn: stream pop way %0d word %0h", e.way, bus8.out_word);
        end
      end
      if (bus8.in_valid && bus8.in_ready) begin
        e.line = bus8.lines[way_r*512 +: 512];
        e.word = mode_r ? bus8.lines[way_r*512 + wsel_r*32 +: 32] : 32'h0;
        e.way  = way_r;
        q.push_back(e);
        sent++;
      end
      tick();
      cyc++;
    end
    check("stream_sent", sent, 100);
    check("stream_left", q.size(), 0);

    // Reset while holding two entries
    $display("txn: reset in TWO");
    for (int w = 0; w < 8; w++) bus8.lines[w*512 +: 512] = pat(w);
    bus8.out_ready = 0; bus8.word_mode = 0;
    bus8.in_valid = 1; bus8.way_sel = 1;
    tick();
    bus8.way_sel = 2;
    tick();
    bus8.in_valid = 0;
    check("rt_full", bus8.in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("rt_valid", bus8.out_valid, 0);
    check("rt_ready", bus8.in_ready, 1);
    check("rt_line", bus8.out_line, 0);
    check("rt_cnt6", bus6.err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    bus8.in_valid = 1; bus8.way_sel = 6; bus8.word_sel = 2; bus8.word_mode = 1; bus8.out_ready = 1;
    tick();
    bus8.in_valid = 0;
    check("rt_post_valid", bus8.out_valid, 1);
    check("rt_post_line", bus8.out_line, pat(6));
    check("rt_post_word", bus8.out_word, 32'h6);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/way_line_select.md
# way_line_select

Registered, flow-controlled successor to the combinational way multiplexor in the L2 data path. It takes the concatenated data lines of all ways in a set and a way index, and returns the selected line one cycle later; optionally it also returns one word from that line. It sits between the tag-compare/hit logic and the L1 fill / processor-read return path. A two-entry output buffer lets the block absorb downstream back-pressure without combinational ready paths.

## Interface
- LINE_SIZE, 512, bits per cache line
- WAYS, 8, associativity; any value ≥ 2, not restricted to powers of two
- WORD_SIZE, 32, bits per word; LINE_SIZE must be a multiple of WORD_SIZE
- ERR_CNT_W, 16, width of the saturating error counter

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request this cycle
- way_sel  in  $clog2(WAYS)  way index
- word_sel  in  $clog2(LINE_SIZE/WORD_SIZE)  word index within line
- word_mode  in  1  1 = also extract word
- lines  in  WAYS*LINE_SIZE  way w occupies bits [w*LINE_SIZE +: LINE_SIZE]
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- out_line  out  LINE_SIZE  selected line
- out_word  out  WORD_SIZE  selected word
- out_err  out  1  way_sel was out of range
- err_count  out  ERR_CNT_W  saturating count of out-of-range requests accepted

## Operation
- Accept = in_valid && in_ready. Inputs are sampled only on accept; lines need only be stable in the accept cycle.
- Selection: line = lines[way_sel*LINE_SIZE +: LINE_SIZE]. Word = line[word_sel*WORD_SIZE +: WORD_SIZE] when word_mode=1, else 0.
- Range check: way_sel ≥ WAYS → err=1, line=0, word=0. This is possible only for non-power-of-two WAYS.
- Each accepted request becomes one entry {line, word, err} in a 2-deep FIFO: a head register and a skid register.
- Buffer states: EMPTY, ONE, TWO.
  - EMPTY: accept → ONE.
  - ONE: accept and no pop → TWO. Pop and no accept → EMPTY. Both → ONE, with the new entry replacing the head.
  - TWO: pop → ONE, with the skid entry moving to head. No accept is possible in TWO.
- Pop = out_valid && out_ready.
- in_ready = (state != TWO). It is a registered function of state only and never depends on out_ready.
- out_valid = (state != EMPTY). out_line, out_word and out_err show the head entry and stay stable while out_valid && !out_ready.
- err_count increments by 1 on every accept whose err=1 and saturates at 2^ERR_CNT_W−1.

## Timing
- Latency: accept in cycle N → out_valid=1 with that result in cycle N+1 when the buffer was EMPTY at N, or when it was ONE and popped at N.
- Throughput: 1 request/cycle while out_ready=1.
- Reset (async assert, any time, including mid-transfer): state=EMPTY, in_ready=1, out_valid=0, out_line=0, out_word=0, out_err=0, err_count=0. Buffered entries are discarded.
- Reset release: first accept is possible on the first rising edge after deassertion.
- Simultaneous accept and pop in ONE: the popped entry is the old head; the new entry is visible next cycle. No bubble, no duplicate.
- Order is strictly FIFO; no entry is dropped or reordered under any in_valid/out_ready pattern.

## Structure
- Package way_select_pkg:
  - localparams WAY_IDX_W = $clog2(WAYS) and WORD_IDX_W = $clog2(LINE_SIZE/WORD_SIZE), as functions of the parameters.
  - typedef enum for buffer state {EMPTY, ONE, TWO}.
  - Packed-struct typedef for the entry {line, word, err}.
- One sub-module is natural: way_select_skid, a generic 2-entry valid/ready buffer parameterised on payload width. The top level is the combinational select/extract/range check plus the error counter.

## Test plan
- WAYS=8, lines set so way w = {16{32'(w)}}; way_sel=5, word_mode=0, out_ready=1 → next cycle out_valid=1, out_line = way 5 pattern, out_word=0, out_err=0.
- Same lines; way_sel=3, word_sel=15, word_mode=1 → out_word=32'h3, out_line = way 3 pattern.
- Back-pressure: out_ready=0, issue 3 back-to-back requests (ways 1, 2, 3) → in_ready falls after the 2nd accept; 3rd held. Raise out_ready → outputs 1, 2, 3 in order, no loss.
- WAYS=6, way_sel=7 → out_err=1, out_line=0, err_count=1. With ERR_CNT_W=2, 5 such requests → err_count=3 (saturated).
- Streaming: 100 random requests with random out_ready → scoreboard matches every result in order; accepts never occur while in_ready=0.
- Assert reset while the buffer is in TWO → out_valid=0, in_ready=1, err_count=0 immediately. After release, a new request returns correctly one cycle after accept.
